systolic_mac_pe: RTL
====================

Name: systolic_mac_pe

Overview:
Output-stationary systolic processing element, the parametrised successor to the single-width MAC cell. It forwards operands east/south with one-cycle latency and accumulates signed fixed-point products at full precision with guard bits. It rounds and saturates once per dot product and applies optional ReLU. Results leave through a column drain chain, so the array can accumulate the next vector while the previous results shift out.

Parameters:
N, 16, operand/result width, signed two's complement
FRAC, 10, fractional bits of operands and result (Q(N-FRAC).FRAC); 1 <= FRAC < N
GUARD, 8, extra accumulator bits; ACC_W = 2N+GUARD

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
a_in  in  N  west operand
b_in  in  N  north operand
valid_in  in  1  a_in/b_in form a valid term
first_in  in  1  term is the first of a dot product (qualified by valid_in)
last_in  in  1  term is the last of a dot product (qualified by valid_in)
relu_en  in  1  quasi-static; clamp negative results to 0
a_out  out  N  registered a_in
b_out  out  N  registered b_in
valid_out, first_out, last_out  out  1 each  registered sideband
shift_en  in  1  drain chain advance (column-wide)
psum_in  in  N  drain data from upstream PE (tie to 0 at column head)
psum_valid_in  in  1  drain valid from upstream
psum_out  out  N  drain register
psum_valid_out  out  1  drain register holds a result
clr_err  in  1  clears sticky flags
acc_sat  out  1  sticky: accumulator saturated
overrun  out  1  sticky: unshifted result overwritten

Behaviour:
- Reset: all outputs, the accumulator and the FSM go to 0/IDLE immediately; reset mid-dot-product discards the partial sum.
- Passthrough: a_out, b_out, valid_out, first_out and last_out equal the previous-cycle inputs, unconditionally.
- Product: signed N x N to signed 2N, full precision. acc_next = (first_in ? 0 : acc) + product, computed in ACC_W bits and saturated to the ACC_W signed range. Saturation sets acc_sat.
- FSM: IDLE, ACC. Updates occur only when valid_in=1.
  - IDLE: valid treats the term as first regardless of first_in. With last_in the state stays IDLE; otherwise it goes to ACC.
  - ACC: first_in restarts the accumulation. last_in completes it and returns to IDLE.
  - valid_in=0: hold state and accumulator.
- Completion (valid&last): on the same edge, res = sat_N((acc_next + 2^(FRAC-1)) >>> FRAC), i.e. round half up with an arithmetic shift. If relu_en and res<0, res=0. The next edge loads psum_out with res and sets psum_valid_out=1. Latency from last term at input to result at psum_out is 1 cycle.
- Drain, with completion not present: shift_en sets psum_out<=psum_in and psum_valid_out<=psum_valid_in. No shift_en means hold.
- Completion and drain priority:
  - Completion with shift_en in the same cycle: the local result wins. overrun sets if psum_valid_in=1.
  - Completion while psum_valid_out=1 and no shift_en: overwrite and set overrun.
- Sticky flags: cleared only by rst or clr_err. If clr_err and a new set event occur in the same cycle, set wins.
- Accumulator is not cleared after completion; the next first term restarts it.

Test Plan:
Values use N=16, FRAC=10; 1.0 = 1024.
1. Passthrough: a_in=0x1234, b_in=0xABCD at cycle t -> a_out=0x1234, b_out=0xABCD at t+1; sideband delayed one cycle identically.
2. Dot product: (2048,3072 first), (1536,-2048), (512,512 last) -> psum_out=3328 (3.25), psum_valid_out=1 one cycle after the last term; acc_sat=0.
3. Rounding and ReLU:
   - a=1, b=512, first&last -> psum_out=1 (half rounds up).
   - a=-1024, b=1024 -> psum_out=0xFC00 with relu_en=0, 0 with relu_en=1.
4. Saturation: 300 terms of a=b=0x7FFF, then last -> psum_out=0x7FFF.
   - Same with b=0x8000 -> psum_out=0x8000.
   - acc_sat stays 0; the guard bits suffice.
5. Drain chain of 3 PEs with results 10, 20, 30 (head to tail), then shift_en for 3 cycles -> tail psum_out sequence 30, 20, 10. psum_valid_out then deasserts at the head first.
6. Hazards:
   - Completion while psum_valid_out=1 and no shift -> new value loaded, overrun=1; clr_err clears it.
   - rst asserted mid-vector (async, no clock edge) -> all outputs 0 immediately; the next vector computes correctly from zero.

Source files
------------

// File: rtl/systolic_mac_pe.sv
// Output-stationary systolic MAC processing element: east/south operand forwarding,
// guarded full-precision accumulation, round/saturate/ReLU once per dot product, column drain chain.
module systolic_mac_pe #(
  parameter int N     = 16,
  parameter int FRAC  = 10,
  parameter int GUARD = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic         valid_in,
  input  logic         first_in,
  input  logic         last_in,
  input  logic         relu_en,
  output logic [N-1:0] a_out,
  output logic [N-1:0] b_out,
  output logic         valid_out,
  output logic         first_out,
  output logic         last_out,
  input  logic         shift_en,
  input  logic [N-1:0] psum_in,
  input  logic         psum_valid_in,
  output logic [N-1:0] psum_out,
  output logic         psum_valid_out,
  input  logic         clr_err,
  output logic         acc_sat,
  output logic         overrun,
  output logic         o_dbg_state
);

  localparam int ACC_W = 2 * N + GUARD;
  localparam logic [ACC_W:0] RND = {{ACC_W{1'b0}}, 1'b1} << (FRAC - 1);

  typedef enum logic {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_eff_first;
  logic               w_done;

  logic [N-1:0]       r_a_out;
  logic [N-1:0]       r_b_out;
  logic               r_valid_out;
  logic               r_first_out;
  logic               r_last_out;
  logic [ACC_W-1:0]   r_acc;
  logic [N-1:0]       r_psum;
  logic               r_psum_valid;
  logic               r_acc_sat;
  logic               r_overrun;

  logic [2*N-1:0]     w_prod;
  logic [ACC_W-1:0]   w_base;
  logic [ACC_W:0]     w_sum;
  logic               w_sum_ovf;
  logic [ACC_W-1:0]   w_acc_next;
  logic [ACC_W:0]     w_rnd;
  logic [ACC_W:0]     w_shr;
  logic [ACC_W-N+1:0] w_hi;
  logic [N-1:0]       w_res_sat;
  logic [N-1:0]       w_res;
  logic               w_ovr_set;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // FSM next state: only valid terms move the machine
  always_comb begin
    w_state_next = r_state;
    if (valid_in) begin
      if (last_in) w_state_next = S_IDLE;
      else         w_state_next = S_ACC;
    end
  end

  // FSM outputs: an IDLE term always starts a fresh dot product
  always_comb begin
    w_eff_first = (r_state == S_IDLE) || first_in;
    w_done      = valid_in && last_in;
  end

  assign o_dbg_state = r_state;

  assign w_prod = $signed(a_in) * $signed(b_in);

  always_comb begin
    w_base    = w_eff_first ? '0 : r_acc;
    w_sum     = {w_base[ACC_W-1], w_base} + {{(GUARD + 1){w_prod[2*N-1]}}, w_prod};
    w_sum_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    if (w_sum_ovf)
      w_acc_next = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      w_acc_next = w_sum[ACC_W-1:0];
  end

  // One extra bit keeps the half-LSB rounding add from wrapping
  always_comb begin
    w_rnd = {w_acc_next[ACC_W-1], w_acc_next} + RND;
    w_shr = $signed(w_rnd) >>> FRAC;
    w_hi  = w_shr[ACC_W:N-1];
    if ((&w_hi) || !(|w_hi))
      w_res_sat = w_shr[N-1:0];
    else
      w_res_sat = w_shr[ACC_W] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    w_res = (relu_en && w_res_sat[N-1]) ? '0 : w_res_sat;
  end

  // A local result displaces whatever the drain register would have held or received
  assign w_ovr_set = w_done && (shift_en ? psum_valid_in : r_psum_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_out      <= '0;
      r_b_out      <= '0;
      r_valid_out  <= 1'b0;
      r_first_out  <= 1'b0;
      r_last_out   <= 1'b0;
      r_acc        <= '0;
      r_psum       <= '0;
      r_psum_valid <= 1'b0;
      r_acc_sat    <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_a_out     <= a_in;
      r_b_out     <= b_in;
      r_valid_out <= valid_in;
      r_first_out <= first_in;
      r_last_out  <= last_in;
      if (valid_in) r_acc <= w_acc_next;
      if (w_done) begin
        r_psum       <= w_res;
        r_psum_valid <= 1'b1;
      end else if (shift_en) begin
        r_psum       <= psum_in;
        r_psum_valid <= psum_valid_in;
      end
      r_acc_sat <= (valid_in && w_sum_ovf) || (r_acc_sat && !clr_err);
      r_overrun <= w_ovr_set || (r_overrun && !clr_err);
    end
  end

  assign a_out          = r_a_out;
  assign b_out          = r_b_out;
  assign valid_out      = r_valid_out;
  assign first_out      = r_first_out;
  assign last_out       = r_last_out;
  assign psum_out       = r_psum;
  assign psum_valid_out = r_psum_valid;
  assign acc_sat        = r_acc_sat;
  assign overrun        = r_overrun;

endmodule
